seg7_bus_writer: RTL and testbench



---
 rtl/seg7_bus_pkg.sv | 19 +
 rtl/seg7_gap_timer.sv | 35 +++
 rtl/seg7_bus_writer.sv | 123 ++++++++++++
 tb/tb_seg7_bus_writer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_bus_pkg.sv
// rtl/seg7_bus_pkg.sv - shared states and addresses for the seven-segment bus writer
package seg7_bus_pkg;

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        WR_LO,
        WR_HI,
        RD_LO_A,
        RD_LO_S,
        RD_HI_A,
        RD_HI_S,
        REL
    } state_t;

    localparam logic [7:0] SEG7_BASE_ADDR = 8'hD0;
    localparam logic [7:0] BUS_IDLE_ADDR  = 8'h00;

endpackage

// File: rtl/seg7_gap_timer.sv
// rtl/seg7_gap_timer.sv - loadable down-counter for rate-limited bus masters
module seg7_gap_timer #(
    parameter int GAP_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [GAP_W-1:0] load_value,
    output logic             zero
);

    logic [GAP_W-1:0] count;
    logic [GAP_W-1:0] count_d;

    always_comb begin
        count_d = count;
        if (load) begin
            count_d = load_value;
        end else if (count != '0) begin
            count_d = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

    // Flags the value the counter takes at the next edge so users can register it.
    assign zero = (count_d == '0);

endmodule

// File: rtl/seg7_bus_writer.sv
// rtl/seg7_bus_writer.sv - bus master pushing 16-bit words to the seven-segment peripheral; SEG7_READBACK_EN adds read-verify
module seg7_bus_writer
    import seg7_bus_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = SEG7_BASE_ADDR,
    parameter int         MIN_GAP   = 1000,
    parameter int         GAP_W     = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        UPD_VALID,
    output logic        UPD_READY,
    input  logic [15:0] UPD_DATA,
    output logic        BUS_REQ,
    input  logic        BUS_GNT,
    output logic [7:0]  BUS_ADDR,
    inout  wire  [7:0]  BUS_DATA,
    output logic        BUS_WE,
`ifdef SEG7_READBACK_EN
    output logic        VERIFY_ERR,
`endif
    output logic        BUSY
);

    localparam logic [7:0]       HI_ADDR  = BASE_ADDR + 8'd1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);

    state_t      state;
    state_t      state_d;
    logic [15:0] hold;
    logic [7:0]  dout;
    logic        drive_en;
    logic        gap_zero;
    logic        transfer;
    logic [7:0]  addr_d;
    logic        drive_d;

    assign transfer = UPD_VALID && UPD_READY;
    assign BUS_DATA = drive_en ? dout : 8'hzz;

    seg7_gap_timer #(.GAP_W(GAP_W)) u_gap (
        .clk        (CLK),
        .rst        (RESET),
        .load       (state == REL),
        .load_value (GAP_LOAD),
        .zero       (gap_zero)
    );

    // Any grant loss while owning the bus restarts the whole sequence from WR_LO.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (transfer) state_d = REQ;
            REQ:     if (BUS_GNT) state_d = WR_LO;
            WR_LO:   state_d = BUS_GNT ? WR_HI : REQ;
`ifdef SEG7_READBACK_EN
            WR_HI:   state_d = BUS_GNT ? RD_LO_A : REQ;
            RD_LO_A: state_d = BUS_GNT ? RD_LO_S : REQ;
            RD_LO_S: state_d = BUS_GNT ? RD_HI_A : REQ;
            RD_HI_A: state_d = BUS_GNT ? RD_HI_S : REQ;
            RD_HI_S: state_d = BUS_GNT ? REL : REQ;
`else
            WR_HI:   state_d = BUS_GNT ? REL : REQ;
`endif
            REL:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d  = BUS_IDLE_ADDR;
        drive_d = 1'b0;
        case (state_d)
            WR_LO:            begin addr_d = BASE_ADDR; drive_d = 1'b1; end
            WR_HI:            begin addr_d = HI_ADDR;   drive_d = 1'b1; end
            RD_LO_A, RD_LO_S: addr_d = BASE_ADDR;
            RD_HI_A, RD_HI_S: addr_d = HI_ADDR;
            default:          addr_d = BUS_IDLE_ADDR;
        endcase
    end

    // Outputs are decoded from the next state so each one lines up with its state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            hold      <= '0;
            UPD_READY <= 1'b0;
            BUSY      <= 1'b0;
            BUS_REQ   <= 1'b0;
            BUS_WE    <= 1'b0;
            BUS_ADDR  <= BUS_IDLE_ADDR;
            drive_en  <= 1'b0;
            dout      <= '0;
        end else begin
            state     <= state_d;
            if (transfer) hold <= UPD_DATA;
            UPD_READY <= (state_d == IDLE) && gap_zero;
            BUSY      <= (state_d != IDLE);
            BUS_REQ   <= !(state_d inside {IDLE, REL});
            BUS_WE    <= drive_d;
            BUS_ADDR  <= addr_d;
            drive_en  <= drive_d;
            dout      <= (state_d == WR_HI) ? hold[15:8] : hold[7:0];
        end
    end

`ifdef SEG7_READBACK_EN
    logic [7:0] rd_lo;

    // The high byte is compared straight off the bus in its sample cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_lo      <= '0;
            VERIFY_ERR <= 1'b0;
        end else begin
            if (state == RD_LO_S) rd_lo <= BUS_DATA;
            VERIFY_ERR <= (state == RD_HI_S) && (state_d == REL) &&
                          ((rd_lo != hold[7:0]) || (BUS_DATA != hold[15:8]));
        end
    end
`endif

endmodule

// File: tb/tb_seg7_bus_writer.sv
// tb/tb_seg7_bus_writer.sv - scoreboard bench for seg7_bus_writer; SEG7_READBACK_EN adds verify tests
module tb_seg7_bus_writer;

    localparam int MIN_GAP = 10;
`ifdef SEG7_READBACK_EN
    localparam int RD_STATES = 4;
`else
    localparam int RD_STATES = 0;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        UPD_VALID = 1'b0;
    logic [15:0] UPD_DATA = '0;
    logic        BUS_GNT = 1'b0;
    logic        UPD_READY;
    logic        BUS_REQ;
    logic        BUS_WE;
    logic        BUSY;
    logic [7:0]  BUS_ADDR;
    wire  [7:0]  BUS_DATA;
    logic        probe = 1'b0;
    logic        pdrv;
    logic [7:0]  pdata;

    // probe drives a sentinel to prove the DUT has let go of the data bus
    assign BUS_DATA = probe ? 8'hA5 : (pdrv ? pdata : 8'hzz);

    always #5 CLK = ~CLK;

`ifdef SEG7_READBACK_EN
    logic       VERIFY_ERR;
    logic [7:0] mem [2];
    logic [7:0] rd_addr_q;
    logic       rd_v = 1'b0;
    logic       stuck = 1'b0;
    int         verr_cnt = 0;

    always @(posedge CLK) begin
        if (BUS_WE && BUS_ADDR == 8'hD0) mem[0] <= BUS_DATA;
        if (BUS_WE && BUS_ADDR == 8'hD1) mem[1] <= BUS_DATA;
        rd_v      <= BUS_REQ && !BUS_WE && (BUS_ADDR == 8'hD0 || BUS_ADDR == 8'hD1);
        rd_addr_q <= BUS_ADDR;
        pdata     <= (BUS_ADDR == 8'hD1) ? (stuck ? 8'h00 : mem[1]) : mem[0];
    end
    assign pdrv = rd_v && BUS_REQ && !BUS_WE && (BUS_ADDR == rd_addr_q);

    always @(negedge CLK) if (VERIFY_ERR) verr_cnt++;
`else
    assign pdrv  = 1'b0;
    assign pdata = 8'h00;
`endif

    seg7_bus_writer #(.MIN_GAP(MIN_GAP)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .UPD_VALID (UPD_VALID),
        .UPD_READY (UPD_READY),
        .UPD_DATA  (UPD_DATA),
        .BUS_REQ   (BUS_REQ),
        .BUS_GNT   (BUS_GNT),
        .BUS_ADDR  (BUS_ADDR),
        .BUS_DATA  (BUS_DATA),
        .BUS_WE    (BUS_WE),
`ifdef SEG7_READBACK_EN
        .VERIFY_ERR(VERIFY_ERR),
`endif
        .BUSY      (BUSY)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  lo_cyc[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    int  xfer_cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: every bus write strobe is popped against the scoreboard.
    always @(negedge CLK) begin
        if (!RESET && BUS_WE) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL bus_write unexpected: addr=%h data=%h", BUS_ADDR, BUS_DATA);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (BUS_ADDR !== e.addr || BUS_DATA !== e.data) begin
                    bad++;
                    $display("FAIL bus_write: got addr=%h data=%h expected addr=%h data=%h",
                             BUS_ADDR, BUS_DATA, e.addr, e.data);
                end
            end
            if (BUS_ADDR == 8'hD0) lo_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_released(input string name);
        probe = 1'b1;
        #1;
        check(name, {24'h0, BUS_DATA}, 32'hA5);
        probe = 1'b0;
    endtask

    task automatic expect_word(input logic [15:0] w);
        exp_q.push_back('{addr: 8'hD0, data: w[7:0]});
        exp_q.push_back('{addr: 8'hD1, data: w[15:8]});
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!UPD_READY && n < 3000) begin
            tick();
            n++;
        end
        if (!UPD_READY) begin
            total++;
            bad++;
            $display("FAIL wait_ready timeout: got ready=0 expected ready=1");
        end
    endtask

    // Leaves the caller in the REQ cycle following the transfer.
    task automatic send(input logic [15:0] w);
        UPD_DATA  = w;
        UPD_VALID = 1'b1;
        wait_ready();
        xfer_cyc = cyc;
        tick();
        UPD_VALID = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) tick();
        RESET = 1'b0;
        check("reset_outputs", {UPD_READY, BUS_REQ, BUS_WE, BUSY, BUS_ADDR}, 32'h0);
        check_released("reset_data_released");
        tick();
        check("ready_after_reset", UPD_READY, 1);

        // Basic write with the grant tied high
        BUS_GNT = 1'b1;
        expect_word(16'h12AB);
        send(16'h12AB);
        check("req_cycle", {BUS_REQ, BUS_WE, BUSY}, 3'b101);
        tick();
        check("wr_lo_strobe", {BUS_WE, BUS_ADDR}, {1'b1, 8'hD0});
        tick();
        check("wr_hi_strobe", {BUS_WE, BUS_ADDR}, {1'b1, 8'hD1});
        repeat (RD_STATES + 1) tick();
        check("rel_outputs", {BUS_REQ, BUS_WE, BUS_ADDR}, 32'h0);
        check_released("rel_data_released");
        check("xfer_to_we", lo_cyc[$] - xfer_cyc, 2);
        n = 0;
        while (!UPD_READY && n < 100) begin
            n++;
            tick();
        end
        check("ready_low_cycles", n, MIN_GAP + 1);

        // Back-to-back words with VALID held high
        lo_cyc.delete();
        expect_word(16'h1357);
        expect_word(16'h2468);
        UPD_DATA  = 16'h1357;
        UPD_VALID = 1'b1;
        wait_ready();
        tick();
        UPD_DATA = 16'h2468;
        wait_ready();
        tick();
        UPD_VALID = 1'b0;
        wait_ready();
        check("rate_writes", lo_cyc.size(), 2);
        check("rate_spacing", lo_cyc[1] - lo_cyc[0], MIN_GAP + 5 + RD_STATES);

        // Grant withheld for seven cycles
        BUS_GNT = 1'b0;
        expect_word(16'h3C5A);
        send(16'h3C5A);
        n = 0;
        for (int i = 0; i < 7; i++) begin
            if (!(BUS_REQ && !BUS_WE)) n++;
            tick();
        end
        check("gnt_wait_req_hold", n, 0);
        BUS_GNT = 1'b1;
        tick();
        check("gnt_to_wr_lo", {BUS_WE, BUS_ADDR}, {1'b1, 8'hD0});
        wait_ready();

        // Grant lost during WR_HI, sequence restarts from the low byte
        expect_word(16'hBEEF);
        expect_word(16'hBEEF);
        send(16'hBEEF);
        tick();
        tick();
        BUS_GNT = 1'b0;
        tick();
        check("gnt_loss_we_drop", {BUS_REQ, BUS_WE}, 2'b10);
        BUS_GNT = 1'b1;
        wait_ready();

        // Reset during WR_LO abandons the word
        send(16'h7777);
        tick();
        RESET = 1'b1;
        tick();
        check("mid_reset_outputs", {UPD_READY, BUS_REQ, BUS_WE, BUSY, BUS_ADDR}, 32'h0);
        check_released("mid_reset_data_released");
        RESET = 1'b0;
        tick();
        check("mid_reset_ready", UPD_READY, 1);
        expect_word(16'h0102);
        send(16'h0102);
        wait_ready();

`ifdef SEG7_READBACK_EN
        verr_cnt = 0;
        expect_word(16'h5A5A);
        send(16'h5A5A);
        wait_ready();
        check("verify_ok_no_pulse", verr_cnt, 0);
        stuck = 1'b1;
        expect_word(16'h5A5A);
        send(16'h5A5A);
        wait_ready();
        check("verify_stuck_pulse", verr_cnt, 1);
`endif

        repeat (5) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
